fan_pwm_capture: RTL and testbench
==================================

Name: fan_pwm_capture

Overview:
- Measures the fan PWM waveform produced by the fan controller: high time and period, in clk_en_i samples.
- Publishes each complete period with a one-cycle strobe.
- Flags a stuck pin (constant 0 % or 100 % duty).
- Sits on the board/bench side of the PWM pin. It closes the loop for self-test, and can feed a measured duty back as an ADC_value-style word with a dataVaild-style strobe.

Parameters:
- CNT_BITWIDTH, 10, width of the sample counter and of the count outputs.
- TIMEOUT_CYCLES, 1000, samples without any edge before the stuck condition is declared. Must be ≤ 2^CNT_BITWIDTH-1 and > the longest legal period (320).

Ports:
- clk_i  in  1  system clock (10 MHz)
- rstn_i  in  1  asynchronous active-low reset
- clk_en_i  in  1  sample enable; all counting/sampling advances only when high
- pwm_i  in  1  asynchronous PWM pin to be measured
- high_count_o  out  CNT_BITWIDTH  samples pwm was high in the last complete period
- period_count_o  out  CNT_BITWIDTH  samples in the last complete period (rising edge to rising edge)
- dataVaild_STRB_o  out  1  one-clk_i pulse when the count outputs/stuck flags update
- stuck_o  out  1  no edge seen for TIMEOUT_CYCLES samples
- stuck_level_o  out  1  synchronized pin level when stuck_o was set (1 = 100 %, 0 = 0 %)

Behaviour:
- Reset (async, rstn_i=0): all outputs 0, synchronizer flops 0, edge-history flop 0, cnt=0, high_latch=0, state=WAIT_RISE.
- Input path:
  - 2-flop synchronizer on pwm_i, clocked on clk_i, advancing only when clk_en_i=1.
  - A third flop holds the previous synchronized sample.
  - rise = sync & ~prev; fall = ~sync & prev; both evaluated only on enabled cycles.
  - Pin-to-edge latency: 2 enabled samples for the synchronizer plus 1 sample for edge detection.
- cnt (CNT_BITWIDTH) runs in every state on enabled cycles:
  - rise → cnt<=1.
  - otherwise cnt<=cnt+1, saturating at all-ones.
  - fall does not reset cnt.
- States:
  - WAIT_RISE: no valid period start. On rise → MEASURE, no strobe. On fall: no action.
  - MEASURE:
    - On fall: high_latch<=cnt (the value before increment).
    - On rise: period_count_o<=cnt, high_count_o<=high_latch, stuck_o<=0, dataVaild_STRB_o=1 for that clk_i cycle; stay in MEASURE.
    - Net result: a waveform high H samples and low L samples reports high=H, period=H+L.
  - STUCK: outputs hold.
    - On rise → MEASURE, no strobe; first period after recovery is discarded as incomplete. stuck_o stays 1 until the first valid strobe.
    - On fall → WAIT_RISE.
- Timeout: in any state other than STUCK, when cnt==TIMEOUT_CYCLES on an enabled cycle with no edge:
  - state<=STUCK, stuck_o<=1, stuck_level_o<=sync.
  - high_count_o<=(sync ? TIMEOUT_CYCLES : 0), period_count_o<=TIMEOUT_CYCLES.
  - One strobe.
- Strobe rules:
  - Exactly one clk_i cycle wide, even if clk_en_i stays high continuously.
  - Never asserted when clk_en_i=0.
  - Rise and timeout on the same sample: rise wins and no timeout fires.
- clk_en_i=0: all state, counters and outputs hold; strobe 0.
- Reset mid-period: immediate clear. The first strobe after reset needs two rising edges.

Test Plan:
- Reset, then PWM high 65 / low 255 samples, clk_en_i=1, 3 periods → no strobe on the first rise. Strobes on the 2nd and 3rd rise with high=65, period=320, stuck_o=0; each strobe exactly 1 cycle.
- Duty changes from 65/320 to 200/320 mid-run → next strobe reports 200/320; the intermediate period reports the mixed high correctly.
- pwm_i held 1 for >1000 samples after running → one strobe with stuck_o=1, stuck_level_o=1, high=1000, period=1000. Then 65/255 resumes → stuck cleared only at the second rise after recovery, reporting 65/320.
- pwm_i held 0 from reset → strobe after 1000 samples with stuck_o=1, stuck_level_o=0, high=0; no further strobes while it stays 0.
- clk_en_i toggling 1-of-2 cycles with PWM of 130/640 clk_i cycles → reports 65/320; strobe 1 clk_i wide.
- rstn_i asserted mid-high-phase → all outputs 0 immediately (async). After release, needs 2 rises before the first strobe.

Source files
------------

// File: rtl/fan_pwm_capture.sv
// Measures high time and period of an external fan PWM pin in clk_en_i samples,
// publishing each complete period with a strobe and flagging a stuck pin.
//
// state     | meaning
// WAIT_RISE | no valid period start yet; waiting for a rising edge
// MEASURE   | a period is in progress; each rise closes the previous one
// STUCK     | no edge for TIMEOUT_CYCLES samples; outputs hold until recovery
module fan_pwm_capture #(
    parameter int CNT_BITWIDTH   = 10,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    clk_en_i,
    input  logic                    pwm_i,
    output logic [CNT_BITWIDTH-1:0] high_count_o,
    output logic [CNT_BITWIDTH-1:0] period_count_o,
    output logic                    dataVaild_STRB_o,
    output logic                    stuck_o,
    output logic                    stuck_level_o
);

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        MEASURE   = 2'd1,
        STUCK     = 2'd2
    } state_t;

    localparam logic [CNT_BITWIDTH-1:0] TIMEOUT = CNT_BITWIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_BITWIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITWIDTH-1:0] CNT_ONE = CNT_BITWIDTH'(1);

    state_t                  state_q, state_d;
    logic                    sync1_q, sync2_q, prev_q;
    logic [CNT_BITWIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_BITWIDTH-1:0] high_latch_q, high_latch_d;
    logic [CNT_BITWIDTH-1:0] high_d, period_d;
    logic                    stuck_d, stuck_level_d;
    logic                    strobe;
    logic                    rise, fall, timeout;

    assign rise    = clk_en_i & sync2_q & ~prev_q;
    assign fall    = clk_en_i & ~sync2_q & prev_q;
    assign timeout = clk_en_i & (state_q != STUCK) & (cnt_q == TIMEOUT) & ~rise & ~fall;

    // Strobe is combinational so it can only ever be high on an enabled cycle;
    // the count outputs take their new values on the clock edge ending it.
    assign dataVaild_STRB_o = strobe;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else if (clk_en_i) begin
            sync1_q <= pwm_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= WAIT_RISE;
            cnt_q          <= '0;
            high_latch_q   <= '0;
            high_count_o   <= '0;
            period_count_o <= '0;
            stuck_o        <= 1'b0;
            stuck_level_o  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            high_latch_q   <= high_latch_d;
            high_count_o   <= high_d;
            period_count_o <= period_d;
            stuck_o        <= stuck_d;
            stuck_level_o  <= stuck_level_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        high_latch_d  = high_latch_q;
        high_d        = high_count_o;
        period_d      = period_count_o;
        stuck_d       = stuck_o;
        stuck_level_d = stuck_level_o;
        strobe        = 1'b0;

        if (clk_en_i) begin
            if (rise) begin
                cnt_d = CNT_ONE;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        case (state_q)
            WAIT_RISE: begin
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (fall) begin
                    high_latch_d = cnt_q;
                end
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = high_latch_q;
                    stuck_d  = 1'b0;
                    strobe   = 1'b1;
                end
            end
            STUCK: begin
                // First period after recovery is incomplete, so no strobe here.
                if (rise) begin
                    state_d = MEASURE;
                end else if (fall) begin
                    state_d = WAIT_RISE;
                end
            end
            default: begin
                state_d = WAIT_RISE;
            end
        endcase

        if (timeout) begin
            state_d       = STUCK;
            stuck_d       = 1'b1;
            stuck_level_d = sync2_q;
            high_d        = sync2_q ? TIMEOUT : '0;
            period_d      = TIMEOUT;
            strobe        = 1'b1;
        end
    end

endmodule

// File: tb/tb_fan_pwm_capture.sv
// Self-checking bench for fan_pwm_capture: table-driven waveforms, hand-written
// stuck/reset corner cases and randomized duty against a period-level model.
module tb_fan_pwm_capture;

    localparam int W = 10;

    logic         clk_i = 1'b0;
    logic         rstn_i = 1'b0;
    logic         clk_en_i = 1'b0;
    logic         pwm_i = 1'b0;
    logic [W-1:0] high_count_o;
    logic [W-1:0] period_count_o;
    logic         dataVaild_STRB_o;
    logic         stuck_o;
    logic         stuck_level_o;

    fan_pwm_capture #(.CNT_BITWIDTH(W), .TIMEOUT_CYCLES(1000)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .clk_en_i         (clk_en_i),
        .pwm_i            (pwm_i),
        .high_count_o     (high_count_o),
        .period_count_o   (period_count_o),
        .dataVaild_STRB_o (dataVaild_STRB_o),
        .stuck_o          (stuck_o),
        .stuck_level_o    (stuck_level_o)
    );

    always #50 clk_i = ~clk_i;

    typedef struct {
        int h;
        int p;
        int st;
        int lv;
    } rep_t;

    typedef struct {
        int h;
        int l;
        int div;
        int exp_h;
        int exp_p;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    rep_t rep_q[$];
    rep_t exp_q[$];
    bit   pending = 0;
    bit   prev_strb = 0;

    int   en_mode = 0;
    int   en_div = 1;
    int   phase = 0;
    bit   m_armed = 0;
    int   m_h = 0;
    int   m_l = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // Captures the published counts on the sample after each strobe.
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (!rstn_i) begin
                pending   = 0;
                prev_strb = 0;
            end else begin
                if (pending) begin
                    rep_q.push_back('{int'(high_count_o), int'(period_count_o),
                                      int'(stuck_o), int'(stuck_level_o)});
                end
                if (dataVaild_STRB_o) begin
                    check("strobe_enabled", int'(clk_en_i), 1);
                    check("strobe_width", int'(prev_strb), 0);
                end
                pending   = dataVaild_STRB_o;
                prev_strb = dataVaild_STRB_o;
            end
        end
    end

    task automatic step(input logic lvl, output bit en);
        @(negedge clk_i);
        pwm_i = lvl;
        if (en_mode == 2) en = 1'($urandom_range(0, 1));
        else begin
            en = (phase % en_div) == 0;
            phase++;
        end
        clk_en_i = en;
    endtask

    task automatic drive(input logic lvl, input int n);
        int k = 0;
        bit en;
        while (k < n) begin
            step(lvl, en);
            if (en) k++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rstn_i   = 1'b0;
        pwm_i    = 1'b0;
        clk_en_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        rep_q.delete();
        exp_q.delete();
        m_armed = 0;
        phase   = 0;
    endtask

    // Model: every rise after an armed period reports that period's H and H+L.
    task automatic model_rise();
        if (m_armed) exp_q.push_back('{m_h, m_h + m_l, 0, 0});
    endtask

    task automatic play(input int h, input int l);
        model_rise();
        m_armed = 1;
        m_h = h;
        m_l = l;
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    task automatic final_rise();
        model_rise();
        m_armed = 0;
        drive(1'b1, 8);
    endtask

    task automatic compare_reports(input string name);
        int n;
        check({name, "_count"}, rep_q.size(), exp_q.size());
        n = (rep_q.size() < exp_q.size()) ? rep_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({name, "_high"}, rep_q[i].h, exp_q[i].h);
            check({name, "_period"}, rep_q[i].p, exp_q[i].p);
            check({name, "_stuck"}, rep_q[i].st, exp_q[i].st);
            if (exp_q[i].st == 1) check({name, "_level"}, rep_q[i].lv, exp_q[i].lv);
        end
        rep_q.delete();
        exp_q.delete();
    endtask

    task automatic check_zero(input string name);
        check({name, "_strobe"}, int'(dataVaild_STRB_o), 0);
        check({name, "_high"}, int'(high_count_o), 0);
        check({name, "_period"}, int'(period_count_o), 0);
        check({name, "_stuck"}, int'(stuck_o), 0);
        check({name, "_level"}, int'(stuck_level_o), 0);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{65, 255, 1, 65, 320};
        vecs[1] = '{65, 255, 2, 65, 320};
        vecs[2] = '{1, 1, 1, 1, 2};
        vecs[3] = '{319, 1, 1, 319, 320};
        vecs[4] = '{200, 120, 3, 200, 320};

        do_reset();
        #1;
        check_zero("reset_state");

        for (int v = 0; v < 5; v++) begin
            en_mode = 0;
            en_div  = vecs[v].div;
            do_reset();
            drive(1'b0, 10);
            repeat (3) begin
                drive(1'b1, vecs[v].h);
                drive(1'b0, vecs[v].l);
            end
            drive(1'b1, 8);
            for (int r = 0; r < 3; r++) exp_q.push_back('{vecs[v].exp_h, vecs[v].exp_p, 0, 0});
            compare_reports($sformatf("vec%0d", v));
        end

        // Duty change, including a mixed period.
        en_mode = 0;
        en_div  = 1;
        do_reset();
        drive(1'b0, 10);
        play(65, 255);
        play(65, 255);
        play(65, 120);
        play(200, 120);
        final_rise();
        compare_reports("duty_change");

        // Stuck high after running, then recovery.
        do_reset();
        drive(1'b0, 10);
        play(65, 255);
        play(65, 255);
        model_rise();
        m_armed = 0;
        exp_q.push_back('{1000, 1000, 1, 1});
        drive(1'b1, 1100);
        check("stuck_hi_flag", int'(stuck_o), 1);
        drive(1'b0, 255);
        play(65, 255);
        check("stuck_hi_hold", int'(stuck_o), 1);
        play(65, 255);
        final_rise();
        check("stuck_hi_clear", int'(stuck_o), 0);
        compare_reports("stuck_hi");

        // Stuck low from reset, direct STUCK->MEASURE recovery.
        do_reset();
        exp_q.push_back('{0, 1000, 1, 0});
        drive(1'b0, 2500);
        check("stuck_lo_flag", int'(stuck_o), 1);
        play(65, 255);
        check("stuck_lo_hold", int'(stuck_o), 1);
        play(65, 255);
        final_rise();
        compare_reports("stuck_lo");

        // Rise lands on the timeout sample: the rise wins.
        do_reset();
        drive(1'b0, 998);
        play(65, 255);
        final_rise();
        compare_reports("rise_vs_timeout");

        // Asynchronous reset in the middle of a high phase.
        do_reset();
        drive(1'b0, 10);
        play(65, 255);
        play(65, 255);
        model_rise();
        m_armed = 0;
        drive(1'b1, 30);
        compare_reports("pre_reset");
        check("pre_reset_high", int'(high_count_o), 65);
        @(negedge clk_i);
        #3;
        rstn_i = 1'b0;
        pwm_i  = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk_i);
        rstn_i  = 1'b1;
        rep_q.delete();
        exp_q.delete();
        m_armed = 0;
        drive(1'b0, 10);
        play(65, 255);
        play(65, 255);
        final_rise();
        compare_reports("post_reset");

        // Random duty with random sample enables.
        en_mode = 2;
        do_reset();
        drive(1'b0, 5);
        for (int i = 0; i < 20; i++) play($urandom_range(1, 200), $urandom_range(1, 120));
        final_rise();
        compare_reports("rand_en");

        en_mode = 0;
        en_div  = 1;
        do_reset();
        drive(1'b0, 5);
        for (int i = 0; i < 10; i++) play($urandom_range(1, 319), 1 + $urandom_range(0, 0));
        for (int i = 0; i < 10; i++) play($urandom_range(1, 100), $urandom_range(1, 220));
        final_rise();
        compare_reports("rand_full");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
